// File: rtl/arb_pkg.sv
// Shared definitions for the rotating-priority core arbiter: FSM state
// encoding and the default sizing parameters.
package arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: returns the first set request bit found when
// searching upward from (ptr+1) mod N_REQ with wrap-around. The core at ptr
// itself is examined last, so it has the lowest priority.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_req
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] idx_s;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins
  always_comb begin
    winner  = {PW{1'b0}};
    idx_s   = {PW{1'b0}};
    any_req = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx_s  = PW'((int'(ptr) + i) % N_REQ);
      winner = req[idx_s] ? idx_s : winner;
    end
  end

endmodule

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter granting one shared resource to one of N_REQ cores.
// A tenure lasts while the owner keeps requesting, has not released, and has
// not hit the TIMEOUT limit; every tenure is followed by exactly one idle GAP
// cycle so two grants can never touch.
module core_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout
);

  localparam int              PW      = $clog2(N_REQ);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
  localparam logic [PW-1:0]   PTR_RST = PW'(N_REQ - 1);

  arb_state_t        state_r, state_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic [PW-1:0]     owner_r, owner_s;
  logic              busy_r, busy_s;
  logic              timeout_r, timeout_s;
  logic [TO_W-1:0]   cnt_r, cnt_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [PW-1:0]     winner_s;
  logic              any_req_s;
  logic              end_s;
  logic              limit_s;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Owner gives up voluntarily (request dropped or release strobe)
  assign end_s   = ~req[owner_r] | rel[owner_r];
  // Tenure has reached the configured limit; TIMEOUT of 0 never limits
  assign limit_s = (TIMEOUT != 0) && (cnt_r == TO_LIM);

  // Next-state, next-grant and tenure-counter decisions
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    owner_s   = owner_r;
    busy_s    = busy_r;
    timeout_s = 1'b0;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    case (state_r)
      IDLE, GAP: begin
        if (any_req_s) begin
          state_s = GRANT;
          gnt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          owner_s = winner_s;
          ptr_s   = winner_s;
          busy_s  = 1'b1;
          cnt_s   = TO_W'(1);
        end else begin
          state_s = IDLE;
          gnt_s   = {N_REQ{1'b0}};
          busy_s  = 1'b0;
          cnt_s   = {TO_W{1'b0}};
        end
      end
      GRANT: begin
        if (end_s || limit_s) begin
          state_s   = GAP;
          gnt_s     = {N_REQ{1'b0}};
          busy_s    = 1'b0;
          timeout_s = limit_s;
          cnt_s     = {TO_W{1'b0}};
        end else begin
          state_s = GRANT;
          cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + TO_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {N_REQ{1'b0}};
        busy_s  = 1'b0;
        cnt_s   = {TO_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset gives core 0 first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt_r     <= {N_REQ{1'b0}};
      owner_r   <= {PW{1'b0}};
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= {TO_W{1'b0}};
      ptr_r     <= PTR_RST;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      owner_r   <= owner_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
      cnt_r     <= cnt_s;
      ptr_r     <= ptr_s;
    end
  end

  assign gnt     = gnt_r;
  assign owner   = owner_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_core_rr_arbiter.sv
// Directed bench for core_rr_arbiter: one instance with TIMEOUT=4, one with
// the timeout disabled, plus a long random run on the limited instance.
module tb_core_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = 4'b0000, rel4 = 4'b0000;
  logic [3:0] req0 = 4'b0000, rel0 = 4'b0000;
  logic [3:0] gnt4, gnt0;
  logic [1:0] owner4, owner0;
  logic       busy4, busy0, to4, to0;

  int total = 0;
  int bad   = 0;

  core_rr_arbiter #(.N_REQ(4), .TIMEOUT(4), .TO_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .rel(rel4),
    .gnt(gnt4), .owner(owner4), .busy(busy4), .timeout(to4)
  );

  core_rr_arbiter #(.N_REQ(4), .TIMEOUT(0), .TO_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .rel(rel0),
    .gnt(gnt0), .owner(owner0), .busy(busy0), .timeout(to0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req4 = 4'b0000; rel4 = 4'b0000; req0 = 4'b0000; rel0 = 4'b0000;
    step(); step();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || owner4 !== 2'd0 || to4 !== 1'b0) begin
      bad++; $display("FAIL reset_t4 gnt=%b busy=%b owner=%0d to=%b need 0000 0 0 0", gnt4, busy4, owner4, to4);
    end
    total++;
    if (gnt0 !== 4'b0000 || busy0 !== 1'b0 || owner0 !== 2'd0 || to0 !== 1'b0) begin
      bad++; $display("FAIL reset_t0 gnt=%b busy=%b owner=%0d to=%b need 0000 0 0 0", gnt0, busy0, owner0, to0);
    end
  endtask

  // req sampled on the first edge out of reset, then a full timed-out tenure
  task automatic test_timeout_cycle();
    rst = 1'b0; req4 = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++;
      if (gnt4 !== 4'b0001 || busy4 !== 1'b1 || owner4 !== 2'd0 || to4 !== 1'b0) begin
        bad++; $display("FAIL tenure_c%0d gnt=%b busy=%b owner=%0d to=%b need 0001 1 0 0", c, gnt4, busy4, owner4, to4);
      end
    end
    step();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || to4 !== 1'b1) begin
      bad++; $display("FAIL timeout_gap gnt=%b busy=%b to=%b need 0000 0 1", gnt4, busy4, to4);
    end
    step();
    total++;
    if (gnt4 !== 4'b0001 || busy4 !== 1'b1 || to4 !== 1'b0) begin
      bad++; $display("FAIL regrant gnt=%b busy=%b to=%b need 0001 1 0", gnt4, busy4, to4);
    end
    req4 = 4'b0000;
    step();
    total++;
    if (gnt4 !== 4'b0000 || to4 !== 1'b0) begin
      bad++; $display("FAIL drop_no_pulse gnt=%b to=%b need 0000 0", gnt4, to4);
    end
    step();
  endtask

  // All cores requesting, each owner drops for one cycle after 3 grant cycles
  task automatic test_rotation();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_v;
    req0 = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      exp_v = 4'b0001 << order[t];
      total++;
      if (gnt0 !== exp_v || owner0 !== 2'(order[t]) || busy0 !== 1'b1) begin
        bad++; $display("FAIL rot%0d_grant gnt=%b owner=%0d need %b %0d", t, gnt0, owner0, exp_v, order[t]);
      end
      if (t < 4) begin
        step(); step();
        total++;
        if (gnt0 !== exp_v) begin
          bad++; $display("FAIL rot%0d_hold gnt=%b need %b", t, gnt0, exp_v);
        end
        req0[order[t]] = 1'b0;
        step();
        total++;
        if (gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
          bad++; $display("FAIL rot%0d_gap gnt=%b busy=%b need 0000 0", t, gnt0, busy0);
        end
        req0[order[t]] = 1'b1;
        step();
      end
    end
    req0 = 4'b0000;
    step(); step();
  endtask

  // Owner 2 releases; a non-owner release beforehand must be ignored
  task automatic test_release(input logic r3);
    logic [3:0] exp_v;
    exp_v = r3 ? 4'b1000 : 4'b0001;
    req0 = 4'b0000; rel0 = 4'b0000;
    step(); step(); step();
    req0 = 4'b0100;
    step();
    total++;
    if (gnt0 !== 4'b0100) begin
      bad++; $display("FAIL rel_r%0b_grant2 gnt=%b need 0100", r3, gnt0);
    end
    req0 = {r3, 3'b111}; rel0 = 4'b0010;
    step();
    total++;
    if (gnt0 !== 4'b0100 || busy0 !== 1'b1) begin
      bad++; $display("FAIL rel_r%0b_nonowner gnt=%b busy=%b need 0100 1", r3, gnt0, busy0);
    end
    rel0 = 4'b0100;
    step();
    total++;
    if (gnt0 !== 4'b0000 || to0 !== 1'b0) begin
      bad++; $display("FAIL rel_r%0b_gap gnt=%b to=%b need 0000 0", r3, gnt0, to0);
    end
    rel0 = 4'b0000;
    step();
    total++;
    if (gnt0 !== exp_v) begin
      bad++; $display("FAIL rel_r%0b_next gnt=%b need %b", r3, gnt0, exp_v);
    end
    req0 = 4'b0000;
    step(); step();
  endtask

  // Reset in the middle of core 1's tenure, then priority restarts from core 0
  task automatic test_reset_mid();
    req4 = 4'b0000;
    step(); step(); step();
    req4 = 4'b0010;
    step(); step();
    total++;
    if (gnt4 !== 4'b0010) begin
      bad++; $display("FAIL rmid_grant1 gnt=%b need 0010", gnt4);
    end
    rst = 1'b1;
    step();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || to4 !== 1'b0) begin
      bad++; $display("FAIL rmid_drop gnt=%b busy=%b to=%b need 0000 0 0", gnt4, busy4, to4);
    end
    rst = 1'b0; req4 = 4'b0110;
    step();
    total++;
    if (gnt4 !== 4'b0010 || owner4 !== 2'd1) begin
      bad++; $display("FAIL rmid_ptr gnt=%b owner=%0d need 0010 1", gnt4, owner4);
    end
    req4 = 4'b0000;
    step(); step();
  endtask

  // Owner drops req on the limit cycle: pulse must still appear exactly once
  task automatic test_timeout_drop();
    req4 = 4'b0000;
    step(); step();
    req4 = 4'b0001;
    step(); step(); step(); step();
    total++;
    if (gnt4 !== 4'b0001) begin
      bad++; $display("FAIL tdrop_limit gnt=%b need 0001", gnt4);
    end
    req4 = 4'b0000;
    step();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || to4 !== 1'b1) begin
      bad++; $display("FAIL tdrop_pulse gnt=%b busy=%b to=%b need 0000 0 1", gnt4, busy4, to4);
    end
    step();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || to4 !== 1'b0) begin
      bad++; $display("FAIL tdrop_after gnt=%b busy=%b to=%b need 0000 0 0", gnt4, busy4, to4);
    end
  endtask

  // Random traffic: grant shape every cycle and a bounded wait per core
  task automatic test_random();
    int waitc [4] = '{0, 0, 0, 0};
    int maxw;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) req4[i] = ~req4[i];
        rel4[i] = ($urandom_range(15) == 0);
      end
      step();
      total++;
      if (!$onehot0(gnt4) || busy4 !== (|gnt4) || (busy4 && gnt4[owner4] !== 1'b1)) begin
        bad++; $display("FAIL rnd_shape cyc=%0d gnt=%b busy=%b owner=%0d", cyc, gnt4, busy4, owner4);
      end
      maxw = 0;
      for (int i = 0; i < 4; i++) begin
        if (gnt4[i] || !req4[i]) waitc[i] = 0;
        else waitc[i] = waitc[i] + 1;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      total++;
      if (maxw > 20) begin
        bad++; $display("FAIL rnd_starve cyc=%0d wait=%0d limit=20", cyc, maxw);
        for (int i = 0; i < 4; i++) waitc[i] = 0;
      end
    end
    req4 = 4'b0000; rel4 = 4'b0000;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_timeout_cycle();
    test_rotation();
    test_release(1'b1);
    test_release(1'b0);
    test_reset_mid();
    test_timeout_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
